// File: rtl/mmcm_drp_ctrl.sv
`timescale 1ns/1ps
// MMCM DRP reconfiguration sequencer: holds MMCM in reset, read-modify-writes each entry over DRP, then waits for lock.
// Entry accepted only in IDLE/NEXT (o_ent_ready); one DRP op outstanding; optional readback verify under MMCM_DRP_READBACK_EN.
module mmcm_drp_ctrl #(
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_CYCLES   = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ent_valid,
    output logic        o_ent_ready,
    input  logic [6:0]  i_ent_addr,
    input  logic [15:0] i_ent_mask,
    input  logic [15:0] i_ent_data,
    input  logic        i_ent_last,
    output logic [6:0]  o_drp_daddr,
    output logic [15:0] o_drp_di,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy,
    output logic        o_mmcm_rst,
    input  logic        i_locked,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [1:0]  o_err_code
);

    localparam int MAX_A = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int MAX_T = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
    localparam int CW    = $clog2(MAX_T + 1);
    localparam logic [CW-1:0] DRDY_LIM = CW'(DRDY_TIMEOUT);
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] RST_LIM  = CW'(RST_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, RST_HOLD, READ, READ_WAIT, WRITE, WRITE_WAIT, NEXT, RELEASE, LOCK_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    addr_q, addr_d;
    logic [15:0]   mask_q, mask_d;
    logic [15:0]   data_q, data_d;
    logic          last_q, last_d;
    logic [15:0]   new_q, new_d;
    logic          rst_q, rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [1:0]    err_q, err_d;
    logic          lock_meta_q, lock_sync_q;
    logic          accept;
`ifdef MMCM_DRP_READBACK_EN
    logic          rb_q, rb_d;
`endif

    assign o_ent_ready = ~i_reset & ((state_q == IDLE) | (state_q == NEXT));
    assign accept      = i_ent_valid & o_ent_ready;
    assign o_drp_daddr = addr_q;
    assign o_drp_di    = new_q;
    assign o_mmcm_rst  = rst_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = error_q;
    assign o_err_code  = err_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            new_q       <= '0;
            rst_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
`ifdef MMCM_DRP_READBACK_EN
            rb_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            last_q      <= last_d;
            new_q       <= new_d;
            rst_q       <= rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_q       <= err_d;
            lock_meta_q <= i_locked;
            lock_sync_q <= lock_meta_q;
`ifdef MMCM_DRP_READBACK_EN
            rb_q        <= rb_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        data_d    = data_q;
        last_d    = last_q;
        new_d     = new_q;
        rst_d     = rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        err_d     = err_q;
        o_drp_den = 1'b0;
        o_drp_dwe = 1'b0;
`ifdef MMCM_DRP_READBACK_EN
        rb_d      = rb_q;
`endif

        if (accept) begin
            addr_d = i_ent_addr;
            mask_d = i_ent_mask;
            data_d = i_ent_data;
            last_d = i_ent_last;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rst_d   = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = RST_HOLD;
                end
            end
            RST_HOLD: begin
                if (cnt_q == RST_LIM) begin
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                o_drp_den = 1'b1;
                cnt_d     = CW'(1);
                state_d   = READ_WAIT;
            end
            READ_WAIT: begin
                if (i_drp_drdy) begin
`ifdef MMCM_DRP_READBACK_EN
                    if (rb_q) begin
                        rb_d = 1'b0;
                        if (i_drp_do != new_q) begin
                            error_d = 1'b1;
                            err_d   = 2'd3;
                            rst_d   = 1'b0;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = last_q ? RELEASE : NEXT;
                        end
                    end else begin
                        new_d   = (i_drp_do & mask_q) | (data_q & ~mask_q);
                        state_d = WRITE;
                    end
`else
                    new_d   = (i_drp_do & mask_q) | (data_q & ~mask_q);
                    state_d = WRITE;
`endif
                end else if (cnt_q == DRDY_LIM) begin
                    error_d = 1'b1;
                    err_d   = 2'd1;
                    rst_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                o_drp_den = 1'b1;
                o_drp_dwe = 1'b1;
                cnt_d     = CW'(1);
                state_d   = WRITE_WAIT;
            end
            WRITE_WAIT: begin
                if (i_drp_drdy) begin
`ifdef MMCM_DRP_READBACK_EN
                    rb_d    = 1'b1;
                    state_d = READ;
`else
                    state_d = last_q ? RELEASE : NEXT;
`endif
                end else if (cnt_q == DRDY_LIM) begin
                    error_d = 1'b1;
                    err_d   = 2'd1;
                    rst_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (accept) begin
                    state_d = READ;
                end
            end
            RELEASE: begin
                rst_d   = 1'b0;
                cnt_d   = '0;
                state_d = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                if (lock_sync_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == LOCK_LIM) begin
                    error_d = 1'b1;
                    err_d   = 2'd2;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
`timescale 1ns/1ps
// Directed bench for mmcm_drp_ctrl: DRP/lock behavioural model at negedge, checks at posedge+1.
module tb_mmcm_drp_ctrl;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_ent_valid;
    logic        o_ent_ready;
    logic [6:0]  i_ent_addr;
    logic [15:0] i_ent_mask;
    logic [15:0] i_ent_data;
    logic        i_ent_last;
    logic [6:0]  o_drp_daddr;
    logic [15:0] o_drp_di;
    logic        o_drp_den;
    logic        o_drp_dwe;
    bit   [15:0] i_drp_do;
    bit          i_drp_drdy;
    logic        o_mmcm_rst;
    wire         i_locked;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [1:0]  o_err_code;

    always #5 clk = ~clk;

    mmcm_drp_ctrl dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_ent_valid(i_ent_valid), .o_ent_ready(o_ent_ready),
        .i_ent_addr(i_ent_addr), .i_ent_mask(i_ent_mask),
        .i_ent_data(i_ent_data), .i_ent_last(i_ent_last),
        .o_drp_daddr(o_drp_daddr), .o_drp_di(o_drp_di),
        .o_drp_den(o_drp_den), .o_drp_dwe(o_drp_dwe),
        .i_drp_do(i_drp_do), .i_drp_drdy(i_drp_drdy),
        .o_mmcm_rst(o_mmcm_rst), .i_locked(i_locked),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_err_code(o_err_code)
    );

    // stimulus controls (written by the initial block only)
    int          drp_lat = 3;
    bit          drp_never = 1'b0;
    bit          corrupt = 1'b0;
    logic [15:0] rd_init = 16'h0;
    int          seq_id = 0;
    int          lock_mode = 0;
    bit          glitch_en = 1'b0;

    // model / monitor state (written by the negedge process only)
    int          cyc = 0, done_pulses = 0, err_pulses = 0, both_cnt = 0;
    int          den_overlap = 0, ready_bad = 0, rst_run = 0, rst_falls = 0;
    int          rst_fall_cyc = 0, err_cyc = 0, drdy_fired = 0, pcnt = 0, lk = 0;
    int          wrote_seq = -1;
    bit          pend = 1'b0, rst_prev = 1'b0, lock_lvl = 1'b0, glitch_lvl = 1'b0;
    logic [15:0] last_wr = 16'h0;
    logic [6:0]  wr_addr[$];
    logic [15:0] wr_di[$];
    int          den_cyc_q[$];
    int          den_run_q[$];

    assign i_locked = lock_lvl | glitch_lvl;

    always @(negedge clk) begin
        cyc++;
        if (o_done) done_pulses++;
        if (o_error) begin err_pulses++; err_cyc = cyc; end
        if (o_done && o_error) both_cnt++;
        if (o_ent_ready && o_busy && (pend || o_drp_den)) ready_bad++;
        i_drp_drdy = 1'b0;
        if (pend) begin
            if (pcnt == 0) begin
                i_drp_drdy = 1'b1;
                i_drp_do   = (wrote_seq == seq_id) ? (last_wr ^ {15'd0, corrupt}) : rd_init;
                pend       = 1'b0;
                drdy_fired++;
            end else begin
                pcnt--;
            end
        end
        if (o_drp_den) begin
            if (pend) den_overlap++;
            den_cyc_q.push_back(cyc);
            den_run_q.push_back(rst_run);
            if (o_drp_dwe) begin
                wr_addr.push_back(o_drp_daddr);
                wr_di.push_back(o_drp_di);
                last_wr   = o_drp_di;
                wrote_seq = seq_id;
            end
            if (!drp_never) begin pend = 1'b1; pcnt = drp_lat - 1; end
        end
        if (o_mmcm_rst) rst_run++;
        else begin
            if (rst_prev) begin rst_falls++; rst_fall_cyc = cyc; end
            rst_run = 0;
        end
        rst_prev = o_mmcm_rst;
        case (lock_mode)
            0: begin
                if (o_mmcm_rst) begin lock_lvl = 1'b0; lk = 0; end
                else if (lk < 20) begin lk++; if (lk == 20) lock_lvl = 1'b1; end
            end
            1, 2: lock_lvl = 1'b0;
            default: lock_lvl = 1'b1;
        endcase
    end

    // short lock glitches that never straddle a rising edge
    always begin
        @(posedge clk);
        if (glitch_en) begin
            #($urandom_range(7, 2));
            glitch_lvl = 1'b1;
            #1;
            glitch_lvl = 1'b0;
        end
    end

    int total = 0, bad = 0;
    int wr_base, den_base, done_base, err_base, falls_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_seq();
        seq_id++;
        wr_base    = wr_di.size();
        den_base   = den_cyc_q.size();
        done_base  = done_pulses;
        err_base   = err_pulses;
        falls_base = rst_falls;
    endtask

    task automatic send_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                              input logic l, output bit ok);
        ok = 1'b0;
        i_ent_valid = 1'b1; i_ent_addr = a; i_ent_mask = m; i_ent_data = d; i_ent_last = l;
        for (int i = 0; i < 500; i++) begin
            if (o_ent_ready) begin ok = 1'b1; break; end
            settle(1);
        end
        settle(1);
        i_ent_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_ent_ready) begin ok = 1'b1; break; end
            settle(1);
        end
    endtask

    task automatic wait_end(input int budget, output bit gd, output bit ge);
        gd = 1'b0; ge = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_done) begin gd = 1'b1; break; end
            if (o_error) begin ge = 1'b1; break; end
            settle(1);
        end
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
        logic [15:0] rd;
        logic [15:0] exp_di;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] seq_di[3];
    logic [6:0]  seq_ad[3];

    initial begin
        bit ok, gd, ge;
        int gap_good, fired0;

        vecs[0] = '{7'h08, 16'h1000, 16'h0145, 16'hFFFF, 16'h1145};
        vecs[1] = '{7'h10, 16'h0000, 16'hABCD, 16'h1234, 16'hABCD};
        vecs[2] = '{7'h7F, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h5A5A};
        vecs[3] = '{7'h01, 16'h00FF, 16'h1234, 16'hABCD, 16'h12CD};
        vecs[4] = '{7'h22, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0F0F};
        seq_di  = '{16'h1145, 16'h11AA, 16'h1234};
        seq_ad  = '{7'h08, 7'h09, 7'h0A};

        i_reset = 1'b1; i_ent_valid = 1'b0; i_ent_addr = '0;
        i_ent_mask = '0; i_ent_data = '0; i_ent_last = 1'b0;
        settle(3);
        check("reset_ctrl", {o_mmcm_rst, o_drp_den, o_drp_dwe, o_busy, o_done, o_error, o_err_code, o_ent_ready}, 0);
        check("reset_drp", {o_drp_daddr, o_drp_di}, 0);
        i_reset = 1'b0;
        #1;
        check("ready_post_reset", o_ent_ready, 1);
        settle(25);

        // single-entry sequences
        for (int k = 0; k < 5; k++) begin
            rd_init = vecs[k].rd;
            start_seq();
            send_entry(vecs[k].addr, vecs[k].mask, vecs[k].data, 1'b1, ok);
            check("v_accept", ok, 1);
            wait_end(3000, gd, ge);
            check("v_done", {gd, ge}, 2'b10);
            check("v_idle", {o_busy, o_err_code, o_mmcm_rst}, 0);
            settle(3);
            check("v_nwr", wr_di.size() - wr_base, 1);
            if (wr_di.size() > wr_base) begin
                check("v_di", wr_di[wr_base], vecs[k].exp_di);
                check("v_addr", wr_addr[wr_base], vecs[k].addr);
            end
            if (den_run_q.size() > den_base) check("v_rst_hold_ge4", den_run_q[den_base] >= 4, 1);
            check("v_done_once", done_pulses - done_base, 1);
        end

        // three entries, 10-cycle gap before entry 2
        rd_init = 16'hFFFF;
        start_seq();
        send_entry(7'h08, 16'h1000, 16'h0145, 1'b0, ok);
        wait_ready(500, ok);
        check("m_next1", ok, 1);
        gap_good = 0;
        for (int i = 0; i < 10; i++) begin
            settle(1);
            if (o_ent_ready && o_mmcm_rst && o_busy) gap_good++;
        end
        check("m_gap", gap_good, 10);
        send_entry(7'h09, 16'hFF00, 16'h00AA, 1'b0, ok);
        wait_ready(500, ok);
        check("m_next2", ok, 1);
        send_entry(7'h0A, 16'h0000, 16'h1234, 1'b1, ok);
        wait_end(3000, gd, ge);
        check("m_done", {gd, ge}, 2'b10);
        settle(2);
        check("m_nwr", wr_di.size() - wr_base, 3);
        if (wr_di.size() >= wr_base + 3) begin
            for (int i = 0; i < 3; i++) begin
                check("m_di", wr_di[wr_base + i], seq_di[i]);
                check("m_addr", wr_addr[wr_base + i], seq_ad[i]);
            end
        end
        check("m_rst_falls", rst_falls - falls_base, 1);

        // DRDY never returns
        drp_never = 1'b1;
        start_seq();
        send_entry(7'h05, 16'h0000, 16'h0001, 1'b1, ok);
        wait_end(600, gd, ge);
        check("t_err", {gd, ge}, 2'b01);
        check("t_state", {o_err_code, o_mmcm_rst, o_busy}, {2'd1, 1'b0, 1'b0});
        settle(2);
        check("t_ready", o_ent_ready, 1);
        if (den_cyc_q.size() > den_base) check("t_latency", err_cyc - den_cyc_q[den_base], 256);
        check("t_err_once", err_pulses - err_base, 1);
        drp_never = 1'b0;

        // lock never arrives
        lock_mode = 1;
        start_seq();
        send_entry(7'h06, 16'h0000, 16'h0002, 1'b1, ok);
        wait_end(70000, gd, ge);
        check("l_err", {gd, ge}, 2'b01);
        settle(5);
        check("l_code_sticky", o_err_code, 2);
        check("l_latency", err_cyc - rst_fall_cyc, 65536);
        check("l_no_done", done_pulses - done_base, 0);

        // glitching lock must not complete the sequence
        lock_mode = 2;
        start_seq();
        send_entry(7'h07, 16'h0000, 16'h0003, 1'b1, ok);
        check("g_code_clr", o_err_code, 0);
        for (int i = 0; i < 500 && (rst_falls == falls_base); i++) settle(1);
        check("g_released", rst_falls - falls_base, 1);
        glitch_en = 1'b1;
        settle(300);
        glitch_en = 1'b0;
        check("g_no_done", done_pulses - done_base, 0);
        lock_mode = 3;
        wait_end(50, gd, ge);
        check("g_done", {gd, ge}, 2'b10);
        settle(2);
        lock_mode = 0;

        // reset while a read is outstanding
        drp_lat = 60;
        rd_init = 16'h00F0;
        start_seq();
        send_entry(7'h08, 16'h1000, 16'h0145, 1'b1, ok);
        for (int i = 0; i < 100 && (den_cyc_q.size() == den_base); i++) settle(1);
        settle(5);
        fired0 = drdy_fired;
        i_reset = 1'b1;
        settle(1);
        check("r_outs", {o_mmcm_rst, o_drp_den, o_drp_dwe, o_busy, o_done, o_error, o_err_code, o_ent_ready}, 0);
        check("r_drp", {o_drp_daddr, o_drp_di}, 0);
        i_reset = 1'b0;
        #1;
        check("r_ready", o_ent_ready, 1);
        for (int i = 0; i < 100 && (drdy_fired == fired0); i++) settle(1);
        check("r_drdy_seen", drdy_fired - fired0, 1);
        settle(3);
        check("r_ignored", {o_busy, o_mmcm_rst, o_drp_den}, 0);
        check("r_no_write", wr_di.size() - wr_base, 0);
        check("r_no_pulse", (done_pulses - done_base) + (err_pulses - err_base), 0);
        drp_lat = 3;
        start_seq();
        send_entry(7'h08, 16'h1000, 16'h0145, 1'b1, ok);
        wait_end(3000, gd, ge);
        check("r_new_done", {gd, ge}, 2'b10);
        settle(2);
        if (wr_di.size() > wr_base) check("r_new_di", wr_di[wr_base], 16'h0145);

        // corrupted readback
        corrupt = 1'b1;
        rd_init = 16'h0000;
        start_seq();
        send_entry(7'h08, 16'h1000, 16'h0145, 1'b1, ok);
        wait_end(3000, gd, ge);
`ifdef MMCM_DRP_READBACK_EN
        check("b_err", {gd, ge}, 2'b01);
        check("b_code", {o_err_code, o_mmcm_rst}, {2'd3, 1'b0});
`else
        check("b_done", {gd, ge}, 2'b10);
        check("b_code", o_err_code, 0);
`endif
        corrupt = 1'b0;
        settle(3);

        check("no_overlap", den_overlap, 0);
        check("no_done_and_error", both_cnt, 0);
        check("ready_while_pending", ready_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmcm_drp_ctrl.md
MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 Parameter: DRDY_TIMEOUT, default 255, maximum cycles to wait for o_drp_den→i_drp_drdy before error.
REQ-002 Parameter: LOCK_TIMEOUT, default 65535, maximum cycles to wait for synchronized lock after MMCM reset release.
REQ-003 Parameter: RST_CYCLES, default 4, minimum cycles o_mmcm_rst is held high.
REQ-004 i_clk  in  1  single clock; drives the DRP port (DCLK).
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_ent_valid  in  1  reconfiguration entry valid.
REQ-007 o_ent_ready  out  1  entry accepted when i_ent_valid & o_ent_ready.
REQ-008 i_ent_addr  in  7  DRP register address.
REQ-009 i_ent_mask  in  16  bits set = keep current register bit.
REQ-010 i_ent_data  in  16  new bit values (used where mask bit is 0).
REQ-011 i_ent_last  in  1  final entry of a reconfiguration sequence.
REQ-012 o_drp_daddr  out  7; o_drp_di  out  16; o_drp_den  out  1; o_drp_dwe  out  1  DRP request to the MMCM.
REQ-013 i_drp_do  in  16; i_drp_drdy  in  1  DRP response from the MMCM.
REQ-014 o_mmcm_rst  out  1  MMCM RST, high while reconfiguring.
REQ-015 i_locked  in  1  raw MMCM LOCKED, asynchronous to i_clk.
REQ-016 o_busy  out  1; o_done  out  1 (one-cycle pulse); o_error  out  1 (one-cycle pulse); o_err_code  out  2 (sticky until next sequence start).

Function
REQ-017 i_locked SHALL pass through a 2-flop synchronizer before use; lock detection latency is 2 cycles.
REQ-018 States SHALL be IDLE, RST_HOLD, READ, READ_WAIT, WRITE, WRITE_WAIT, NEXT, RELEASE, LOCK_WAIT.
REQ-019 o_ent_ready SHALL be 1 only in IDLE and NEXT; the accepted entry SHALL be latched internally.
REQ-020 IDLE accept: o_mmcm_rst←1, o_busy←1, o_err_code←0, go to RST_HOLD for RST_CYCLES cycles, then READ.
REQ-021 READ: o_drp_den=1, o_drp_dwe=0 for exactly one cycle with latched address, then READ_WAIT.
REQ-022 READ_WAIT on i_drp_drdy: capture new = (i_drp_do & mask) | (data & ~mask), go to WRITE.
REQ-023 WRITE: o_drp_den=1, o_drp_dwe=1, o_drp_di=new for exactly one cycle, then WRITE_WAIT.
REQ-024 WRITE_WAIT on i_drp_drdy: go to RELEASE if the latched entry had last=1, else NEXT.
REQ-025 NEXT SHALL wait indefinitely for the next entry, with o_mmcm_rst held high; on acceptance go to READ.
REQ-026 RELEASE: o_mmcm_rst←0, clear lock counter, go to LOCK_WAIT.
REQ-027 LOCK_WAIT on synchronized lock=1: o_done pulse, o_busy←0, go to IDLE.
REQ-028 DRDY timeout: a wait state exceeding DRDY_TIMEOUT cycles SHALL give o_err_code=1 and o_error pulse, release o_mmcm_rst, and go to IDLE.
REQ-029 Lock timeout: LOCK_WAIT exceeding LOCK_TIMEOUT cycles SHALL give o_err_code=2, o_error pulse, and return to IDLE.
REQ-030 i_drp_drdy outside a wait state SHALL be ignored.
REQ-031 o_drp_den SHALL never be asserted while a previous DRP request is outstanding.
REQ-032 An entry with last=1 accepted in IDLE SHALL form a complete one-entry sequence.
REQ-033 o_done and o_error SHALL never assert in the same cycle.

Reset
REQ-034 i_reset SHALL act on the i_clk edge, in any state, including mid-DRP-transaction: state←IDLE, counters←0.
REQ-035 All outputs SHALL reset to 0: o_mmcm_rst, o_drp_*, o_busy, o_done, o_error, o_err_code, and o_ent_ready (combinationally 1 in IDLE, so 1 from the first post-reset cycle).
REQ-036 A DRDY arriving after reset from a request issued before reset SHALL be ignored.

Configuration
REQ-037 Macro MMCM_DRP_READBACK_EN defined: after WRITE_WAIT, perform an extra read (READ/READ_WAIT sequence) of the same address; if the data differs from new, set o_err_code=3, pulse o_error, release o_mmcm_rst, and go to IDLE.
REQ-038 Macro undefined: no readback; err_code 3 SHALL never be produced.

Verification
REQ-039 Single entry (addr 0x08, mask 0x1000, data 0x0145), DRP model returns 0xFFFF after 3 cycles, lock rises 20 cycles after release → write DI=0x1145; o_mmcm_rst high ≥4 cycles; o_done pulses once.
REQ-040 Three-entry sequence with a 10-cycle gap before entry 2 → o_ent_ready high only in NEXT; o_mmcm_rst stays high throughout; writes are issued in order.
REQ-041 DRP model never asserts DRDY → o_error pulse 256 cycles after DEN; o_err_code=1; o_mmcm_rst=0; state returns to IDLE.
REQ-042 i_locked held 0 → o_err_code=2 after 65536 LOCK_WAIT cycles; i_locked glitching asynchronously → no false o_done.
REQ-043 i_reset asserted in READ_WAIT, then DRDY pulse → all outputs 0; DRDY is ignored; a new sequence completes normally.
REQ-044 With MMCM_DRP_READBACK_EN, model corrupts readback bit 0 → o_err_code=3; without the macro → o_done.
